pe_share_arbiter: RTL and testbench

- Round-robin arbiter and scheduler that time-shares one pipelined processing element (PE) between NUM_REQ operand requesters.
- Accepts (a, b) operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the PE.
- Tracks each in-flight issue through a tag pipeline matched to the PE latency, and returns each PE result to its originating requester with an ID.
- Sits between operand-generating agents and a shared PE instance inside the compute array.

---
 rtl/pe_share_arbiter.sv | 118 +++++++++++
 tb/tb_pe_share_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_share_arbiter.sv
// rtl/pe_share_arbiter.sv - round-robin scheduler sharing one pipelined PE between requesters
module pe_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int PE_LAT  = 3,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_b,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic                           i_hold,
    output logic                           o_pe_valid,
    output logic [DATA_W-1:0]              o_pe_a,
    output logic [DATA_W-1:0]              o_pe_b,
    input  logic [DATA_W-1:0]              i_pe_result,
    output logic                           o_rsp_valid,
    output logic [ID_W-1:0]                o_rsp_id,
    output logic [DATA_W-1:0]              o_rsp_data,
    output logic                           o_busy
);

    // One extra bit so pointer + offset can exceed NUM_REQ-1 before wrapping.
    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W-1:0] ONE_ID    = ID_W'(1);

    logic [ID_W-1:0]              ptr;
    logic [ID_W-1:0]              grant_id;
    logic                         grant_found;
    logic [ID_W:0]                idx_ext;
    logic                         handshake;
    logic [ID_W-1:0]              issue_id;
    logic [PE_LAT-1:0]            tag_valid;
    logic [PE_LAT-1:0][ID_W-1:0]  tag_id;

    // Rotating priority search: first valid requester at or after the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx_ext     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_ext = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx_ext >= NUM_REQ_X) begin
                idx_ext = idx_ext - NUM_REQ_X;
            end
            if (!grant_found && i_req_valid[idx_ext[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = idx_ext[ID_W-1:0];
            end
        end
    end

    // Grant is suppressed in reset and while issue is held, so no handshake can occur then.
    assign handshake = i_reset_n && !i_hold && grant_found;

    // One-hot ready toward the winning requester only.
    always_comb begin
        o_req_ready = '0;
        if (handshake) begin
            o_req_ready[grant_id] = 1'b1;
        end
    end

    // Issue register: capture the accepted operands and advance the pointer past the winner.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_pe_valid <= 1'b0;
            o_pe_a     <= '0;
            o_pe_b     <= '0;
            issue_id   <= '0;
            ptr        <= '0;
        end else begin
            o_pe_valid <= handshake;
            if (handshake) begin
                o_pe_a   <= i_req_a[grant_id];
                o_pe_b   <= i_req_b[grant_id];
                issue_id <= grant_id;
                ptr      <= (grant_id == LAST_ID) ? '0 : grant_id + ONE_ID;
            end
        end
    end

    // Tag pipeline mirrors the PE latency; it never stalls, so hold only gates new issues.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid[0] <= o_pe_valid;
            tag_id[0]    <= issue_id;
            for (int i = 1; i < PE_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    // Response register: PE result is valid exactly when the last tag stage is occupied.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= tag_valid[PE_LAT-1];
            if (tag_valid[PE_LAT-1]) begin
                o_rsp_id   <= tag_id[PE_LAT-1];
                o_rsp_data <= i_pe_result;
            end
        end
    end

    assign o_busy = (|tag_valid) | o_pe_valid | o_rsp_valid;

endmodule

// File: tb/tb_pe_share_arbiter.sv
// tb/tb_pe_share_arbiter.sv - self-checking bench for pe_share_arbiter
module tb_pe_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int PE_LAT  = 3;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic                           clk;
    logic                           reset_n;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           hold;
    logic                           pe_valid;
    logic [DATA_W-1:0]              pe_a;
    logic [DATA_W-1:0]              pe_b;
    logic [DATA_W-1:0]              pe_result;
    logic                           rsp_valid;
    logic [ID_W-1:0]                rsp_id;
    logic [DATA_W-1:0]              rsp_data;
    logic                           busy;

    pe_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PE_LAT(PE_LAT)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .i_hold      (hold),
        .o_pe_valid  (pe_valid),
        .o_pe_a      (pe_a),
        .o_pe_b      (pe_b),
        .i_pe_result (pe_result),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_data  (rsp_data),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int pe_mode = 0;

    function automatic logic [DATA_W-1:0] pe_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (pe_mode == 0) return a + b;
        return a * b;
    endfunction

    // Behavioural PE: result of the operands shown in cycle C is presented in cycle C+PE_LAT.
    logic [DATA_W-1:0] pe_pipe [0:PE_LAT];
    initial for (int i = 0; i <= PE_LAT; i++) pe_pipe[i] = '0;
    always @(negedge clk) begin
        pe_pipe[0] <= pe_f(pe_a, pe_b);
        for (int i = 1; i <= PE_LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
    end
    assign pe_result = pe_pipe[PE_LAT];

    // Transaction-level reference: rotating pointer plus a queue of expected responses with due cycles.
    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t expq[$];
    int                m_ptr = 0;
    logic              m_pe_valid = 1'b0;
    logic [DATA_W-1:0] m_pe_a = '0;
    logic [DATA_W-1:0] m_pe_b = '0;
    logic              m_rsp_valid = 1'b0;
    int                m_rsp_id = 0;
    logic [DATA_W-1:0] m_rsp_data = '0;
    int                hs_count = 0;

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic               hold;
        logic [NUM_REQ-1:0] exp_ready;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_grant(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic rand_operands();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i] = $urandom;
            req_b[i] = $urandom;
        end
    endtask

    // Compare every output for the current cycle against the model, then advance one clock.
    task automatic step();
        int g;
        logic [NUM_REQ-1:0] exp_ready;
        logic exp_busy;
        exp_t e;
        @(negedge clk);
        g = (reset_n && !hold) ? model_grant(req_valid) : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_busy = 1'b0;
        foreach (expq[k]) if (expq[k].due >= cyc && expq[k].due < cyc + PE_LAT + 2) exp_busy = 1'b1;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            m_rsp_valid = 1'b1;
            m_rsp_id    = e.id;
            m_rsp_data  = e.data;
        end else begin
            m_rsp_valid = 1'b0;
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("pe_valid", 64'(pe_valid), 64'(m_pe_valid));
        check("pe_a", 64'(pe_a), 64'(m_pe_a));
        check("pe_b", 64'(pe_b), 64'(m_pe_b));
        check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        check("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
        check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
        check("busy", 64'(busy), 64'(exp_busy));
        if (!reset_n) begin
            m_ptr = 0;
            expq.delete();
            m_pe_valid = 1'b0;
            m_pe_a = '0;
            m_pe_b = '0;
            m_rsp_id = 0;
            m_rsp_data = '0;
        end else begin
            m_pe_valid = (g >= 0);
            if (g >= 0) begin
                m_pe_a = req_a[g];
                m_pe_b = req_b[g];
                e.due  = cyc + PE_LAT + 2;
                e.id   = g;
                e.data = pe_f(req_a[g], req_b[g]);
                expq.push_back(e);
                m_ptr = (g + 1) % NUM_REQ;
                hs_count++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        hold = 1'b0;
        for (int i = 0; i < PE_LAT + 3; i++) step();
    endtask

    initial begin
        clk = 1'b0;
        reset_n = 1'b0;
        hold = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;

        // Contention from pointer 0, then pointer skip from 2, then hold and idle rows.
        for (int i = 0; i < 8; i++) vecs.push_back('{4'b1111, 1'b0, 4'b0001 << (i % 4)});
        vecs.push_back('{4'b0100, 1'b0, 4'b0100});
        vecs.push_back('{4'b1010, 1'b0, 4'b1000});
        vecs.push_back('{4'b1010, 1'b0, 4'b0010});
        vecs.push_back('{4'b1010, 1'b0, 4'b1000});
        vecs.push_back('{4'b1010, 1'b0, 4'b0010});
        vecs.push_back('{4'b1111, 1'b1, 4'b0000});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000});
        vecs.push_back('{4'b1111, 1'b0, 4'b0100});

        do_reset();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_pe_a", 64'(pe_a), 64'd0);

        // Single request from requester 2 through an adding PE.
        pe_mode = 0;
        req_valid = 4'b0100;
        req_a[2] = 32'd5;
        req_b[2] = 32'd7;
        step();
        req_valid = '0;
        check("single_pe_valid", 64'(pe_valid), 64'd1);
        check("single_pe_a", 64'(pe_a), 64'd5);
        check("single_pe_b", 64'(pe_b), 64'd7);
        for (int i = 0; i < 4; i++) step();
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        check("single_rsp_id", 64'(rsp_id), 64'd2);
        check("single_rsp_data", 64'(rsp_data), 64'd12);
        step();
        check("single_busy_low", 64'(busy), 64'd0);

        // Table vectors.
        do_reset();
        foreach (vecs[i]) begin
            req_valid = vecs[i].valid;
            hold = vecs[i].hold;
            rand_operands();
            #1;
            check("vec_ready", 64'(req_ready), 64'(vecs[i].exp_ready));
            step();
        end
        drain();

        // Hold after two grants: drain continues, grants resume at requester 2.
        do_reset();
        req_valid = 4'b1111;
        rand_operands();
        step();
        step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ready", 64'(req_ready), 64'd0);
            step();
        end
        hold = 1'b0;
        #1;
        check("hold_resume_ready", 64'(req_ready), 64'b0100);
        check("hold_rsp0_valid", 64'(rsp_valid), 64'd1);
        check("hold_rsp0_id", 64'(rsp_id), 64'd0);
        step();
        check("hold_rsp1_valid", 64'(rsp_valid), 64'd1);
        check("hold_rsp1_id", 64'(rsp_id), 64'd1);
        drain();

        // Reset with three issues in flight.
        do_reset();
        req_valid = 4'b1111;
        rand_operands();
        for (int i = 0; i < 3; i++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        req_valid = '0;
        for (int i = 0; i < PE_LAT + 2; i++) begin
            #1;
            check("flush_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        req_valid = 4'b1111;
        #1;
        check("post_reset_grant", 64'(req_ready), 64'b0001);
        step();
        drain();

        // Random traffic through a multiplying PE.
        pe_mode = 1;
        do_reset();
        hs_count = 0;
        for (int c = 0; c < 20000 && hs_count < 1000; c++) begin
            req_valid = NUM_REQ'($urandom);
            hold = ($urandom_range(0, 4) == 0);
            rand_operands();
            step();
        end
        check("random_count", 64'(hs_count >= 1000), 64'd1);
        drain();
        check("random_queue_empty", 64'(expq.size()), 64'd0);
        check("random_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
